// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory-access stage.
//   - inter-stage bus widths (EX->MEM, MEM->WB, MEM->decode forwarding)
//   - ld_type bit positions inside the {ld_w,ld_h,ld_hu,ld_b,ld_bu} field
//   - exception vector width and the address-misalignment bit position
//   - packed view of the EX->MEM bus
package mem_stage_pkg;

    localparam int unsigned E2M_W     = 93;
    localparam int unsigned M2W_W     = 86;
    localparam int unsigned M_RFC_W   = 39;
    localparam int unsigned EXC_W     = 16;
    localparam int unsigned LD_TYPE_W = 5;

    // Bit positions within ld_type = {ld_w, ld_h, ld_hu, ld_b, ld_bu}
    localparam int unsigned LD_W_BIT  = 4;
    localparam int unsigned LD_H_BIT  = 3;
    localparam int unsigned LD_HU_BIT = 2;
    localparam int unsigned LD_B_BIT  = 1;
    localparam int unsigned LD_BU_BIT = 0;

    // Address-misalignment exception bit inside except[]
    localparam int unsigned EXC_ALE_BIT = 9;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          result;
        logic                 rf_we;
        logic [4:0]           rf_waddr;
        logic                 res_from_mem;
        logic                 mem_req;
        logic [LD_TYPE_W-1:0] ld_type;
        logic [EXC_W-1:0]     except;
    } e2m_bus_t;

endpackage

// File: rtl/mem_stage_load.sv
// load_align: combinational load-data extraction.
//   rdata   in  32  raw word returned by the data SRAM
//   addr    in  2   low address bits of the access
//   ld_type in  5   {ld_w, ld_h, ld_hu, ld_b, ld_bu}
//   ld_data out 32  selected byte/half/word, sign- or zero-extended
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0]          rdata,
    input  logic [1:0]           addr,
    input  logic [LD_TYPE_W-1:0] ld_type,
    output logic [31:0]          ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ld_data = rdata;
        if (ld_type[LD_B_BIT])
            ld_data = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_type[LD_BU_BIT])
            ld_data = {24'h0, byte_sel};
        else if (ld_type[LD_H_BIT])
            ld_data = {{16{half_sel[15]}}, half_sel};
        else if (ld_type[LD_HU_BIT])
            ld_data = {16'h0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
//   clk, resetn            clock, synchronous active-low reset
//   es_to_ms_valid/bus     instruction from execute (93-bit bus)
//   ms_allowin             stage can accept an instruction this cycle
//   data_sram_data_ok/rdata  SRAM-like data response (oldest request first)
//   except_flush           writeback-raised exception/ertn flush
//   ws_allowin             writeback can accept
//   ms_to_ws_valid/bus     instruction handed to writeback (86-bit bus)
//   ms_rf_collect          {load_pending, rf_we, rf_waddr, final_result} to decode
//   ms_except              valid instruction carrying an exception
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DISCARD_W = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               es_to_ms_valid,
    output logic               ms_allowin,
    input  logic [E2M_W-1:0]   es_to_ms_bus,
    input  logic               data_sram_data_ok,
    input  logic [31:0]        data_sram_rdata,
    input  logic               except_flush,
    input  logic               ws_allowin,
    output logic               ms_to_ws_valid,
    output logic [M2W_W-1:0]   ms_to_ws_bus,
    output logic [M_RFC_W-1:0] ms_rf_collect,
    output logic               ms_except
);

    e2m_bus_t             ms_bus;
    logic                 ms_valid;
    logic                 data_buf_valid;
    logic [31:0]          data_buf;
    logic [DISCARD_W-1:0] discard_cnt;

    logic        has_except;
    logic        wait_resp;
    logic        resp_here;
    logic        ms_ready_go;
    logic        ms_load_pending;
    logic        accept;
    logic        leave;
    logic        discard_inc;
    logic        discard_dec;
    logic [31:0] load_word;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign has_except  = |ms_bus.except;
    assign wait_resp   = ms_valid & ms_bus.mem_req & ~has_except;
    // A response only belongs to this instruction once all orphans are drained.
    assign resp_here   = data_sram_data_ok & (discard_cnt == '0);
    assign ms_ready_go = ~wait_resp | data_buf_valid | resp_here;

    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~except_flush;

    assign accept = es_to_ms_valid & ms_allowin;
    assign leave  = ms_to_ws_valid & ws_allowin;

    // Flushing an instruction whose response has not yet arrived orphans it.
    assign discard_inc = except_flush & wait_resp & ~data_buf_valid & ~resp_here;
    assign discard_dec = data_sram_data_ok & (discard_cnt != '0);

    assign load_word = data_buf_valid ? data_buf : data_sram_rdata;

    load_align u_load_align (
        .rdata   (load_word),
        .addr    (ms_bus.result[1:0]),
        .ld_type (ms_bus.ld_type),
        .ld_data (load_data)
    );

    assign final_result    = ms_bus.res_from_mem ? load_data : ms_bus.result;
    assign ms_load_pending = ms_valid & ms_bus.res_from_mem & ~ms_ready_go;

    assign ms_to_ws_bus  = {ms_bus.pc, final_result, ms_bus.rf_we,
                            ms_bus.rf_waddr, ms_bus.except};
    assign ms_rf_collect = {ms_load_pending, ms_bus.rf_we & ms_valid,
                            ms_bus.rf_waddr, final_result};
    assign ms_except     = ms_valid & has_except;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid       <= 1'b0;
            ms_bus         <= '0;
            data_buf_valid <= 1'b0;
            data_buf       <= '0;
            discard_cnt    <= '0;
        end else begin
            if (except_flush)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;

            if (accept)
                ms_bus <= es_to_ms_bus;

            if (accept || leave) begin
                data_buf_valid <= 1'b0;
            end else if (resp_here && wait_resp && !ws_allowin) begin
                data_buf_valid <= 1'b1;
                data_buf       <= data_sram_rdata;
            end

            case ({discard_inc, discard_dec})
                2'b10:   discard_cnt <= discard_cnt + DISCARD_W'(1);
                2'b01:   discard_cnt <= discard_cnt - DISCARD_W'(1);
                default: discard_cnt <= discard_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic               clk = 1'b0;
    logic               resetn;
    logic               es_to_ms_valid;
    logic               ms_allowin;
    logic [E2M_W-1:0]   es_to_ms_bus;
    logic               data_sram_data_ok;
    logic [31:0]        data_sram_rdata;
    logic               except_flush;
    logic               ws_allowin;
    logic               ms_to_ws_valid;
    logic [M2W_W-1:0]   ms_to_ws_bus;
    logic [M_RFC_W-1:0] ms_rf_collect;
    logic               ms_except;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;
    int unsigned handoffs = 0;
    int unsigned h0;
    logic        wrap_seen = 1'b0;
    logic        illegal_seen = 1'b0;
    logic [1:0]  last_cnt = 2'd0;

    mem_stage #(.DISCARD_W(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_to_ms_bus      (es_to_ms_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .except_flush      (except_flush),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_rf_collect     (ms_rf_collect),
        .ms_except         (ms_except)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn) begin
            if (ms_to_ws_valid && ws_allowin) handoffs++;
            if (data_sram_data_ok && dut.data_buf_valid) illegal_seen = 1'b1;
            if (last_cnt == 2'd3 && dut.discard_cnt == 2'd0) wrap_seen = 1'b1;
        end
        last_cnt = dut.discard_cnt;
    end

    task automatic check(input string tag, input logic [M2W_W-1:0] got,
                         input logic [M2W_W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [E2M_W-1:0] mk(input logic [31:0] pc,
                                            input logic [31:0] result,
                                            input logic rf_we,
                                            input logic [4:0] waddr,
                                            input logic rfm,
                                            input logic mreq,
                                            input logic [4:0] lt,
                                            input logic [15:0] exc);
        return {pc, result, rf_we, waddr, rfm, mreq, lt, exc};
    endfunction

    function automatic logic [31:0] fin(input logic [M2W_W-1:0] b);
        return b[53:22];
    endfunction

    logic [4:0]  t_lt   [4] = '{5'b01000, 5'b00001, 5'b01000, 5'b00010};
    logic [31:0] t_addr [4] = '{32'h5002, 32'h5001, 32'h5000, 32'h5000};
    logic [31:0] t_rd   [4] = '{32'h8001_1234, 32'h0000_FF00, 32'hFFFF_7FFF, 32'h0000_007F};
    logic [31:0] t_exp  [4] = '{32'hFFFF_8001, 32'h0000_00FF, 32'h0000_7FFF, 32'h0000_007F};

    initial begin
        resetn = 1'b0;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        except_flush = 1'b0;
        ws_allowin = 1'b1;

        tick(); tick();
        check("rst_allowin", 86'(ms_allowin), 86'd1);
        check("rst_valid", 86'(ms_to_ws_valid), 86'd0);
        check("rst_bus", ms_to_ws_bus, '0);
        check("rst_rfc", 86'(ms_rf_collect), '0);
        check("rst_except", 86'(ms_except), 86'd0);
        resetn = 1'b1;

        // ld_b, data_ok two cycles after entry
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h1c00_0000, 32'h1003, 1'b1, 5'd5, 1'b1, 1'b1, 5'b00010, 16'h0);
        tick();
        es_to_ms_valid = 1'b0; #1;
        check("ldb_wait_valid", 86'(ms_to_ws_valid), 86'd0);
        check("ldb_wait_allowin", 86'(ms_allowin), 86'd0);
        check("ldb_load_pending", 86'(ms_rf_collect[38]), 86'd1);
        tick();
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_1234; #1;
        check("ldb_valid", 86'(ms_to_ws_valid), 86'd1);
        check("ldb_result", 86'(fin(ms_to_ws_bus)), 86'hFFFF_FF80);
        check("ldb_pend_clear", 86'(ms_rf_collect[38]), 86'd0);
        tick();
        data_sram_data_ok = 1'b0; #1;
        check("ldb_gone", 86'(ms_to_ws_valid), 86'd0);
        check("ldb_allowin", 86'(ms_allowin), 86'd1);

        // ld_hu, response arrives while writeback stalls
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h1c00_0010, 32'h2002, 1'b1, 5'd6, 1'b1, 1'b1, 5'b00100, 16'h0);
        tick();
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_7FFF; #1;
        h0 = handoffs;
        check("ldhu_resp_result", 86'(fin(ms_to_ws_bus)), 86'h0000_8001);
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF; #1;
        check("ldhu_buf_valid", 86'(dut.data_buf_valid), 86'd1);
        check("ldhu_allowin", 86'(ms_allowin), 86'd0);
        check("ldhu_buf_result", 86'(fin(ms_to_ws_bus)), 86'h0000_8001);
        tick();
        tick();
        ws_allowin = 1'b1; #1;
        check("ldhu_valid", 86'(ms_to_ws_valid), 86'd1);
        check("ldhu_result", 86'(fin(ms_to_ws_bus)), 86'h0000_8001);
        tick();
        check("ldhu_gone", 86'(ms_to_ws_valid), 86'd0);
        tick();
        check("ldhu_once", 86'(handoffs - h0), 86'd1);

        // store flushed before its response, then a load
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h1c00_0020, 32'h3000, 1'b0, 5'd0, 1'b0, 1'b1, 5'b00000, 16'h0);
        tick();
        es_to_ms_valid = 1'b0; except_flush = 1'b1; #1;
        check("st_flush_valid", 86'(ms_to_ws_valid), 86'd0);
        tick();
        except_flush = 1'b0; #1;
        check("st_discard_1", 86'(dut.discard_cnt), 86'd1);
        check("st_allowin", 86'(ms_allowin), 86'd1);
        h0 = handoffs;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h1c00_0024, 32'h4000, 1'b1, 5'd7, 1'b1, 1'b1, 5'b10000, 16'h0);
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0_BAD0; #1;
        check("orphan_hidden", 86'(ms_to_ws_valid), 86'd0);
        tick();
        data_sram_rdata = 32'h1234_5678; #1;
        check("orphan_drained", 86'(dut.discard_cnt), 86'd0);
        check("ldw_valid", 86'(ms_to_ws_valid), 86'd1);
        check("ldw_result", 86'(fin(ms_to_ws_bus)), 86'h1234_5678);
        tick();
        data_sram_data_ok = 1'b0; #1;
        check("ldw_once", 86'(handoffs - h0), 86'd1);

        // flush and data_ok in the same cycle
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h1c00_0030, 32'h4004, 1'b1, 5'd8, 1'b1, 1'b1, 5'b10000, 16'h0);
        tick();
        es_to_ms_valid = 1'b0; except_flush = 1'b1;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_CAFE; #1;
        check("flush_ok_valid", 86'(ms_to_ws_valid), 86'd0);
        tick();
        except_flush = 1'b0; data_sram_data_ok = 1'b0; #1;
        check("flush_ok_discard", 86'(dut.discard_cnt), 86'd0);
        check("flush_ok_allowin", 86'(ms_allowin), 86'd1);

        // exception instruction: no wait for data_ok
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h1c00_0050, 32'h6001, 1'b1, 5'd9, 1'b1, 1'b1, 5'b10000,
                          16'(1) << EXC_ALE_BIT);
        tick();
        es_to_ms_valid = 1'b0; #1;
        check("exc_ms_except", 86'(ms_except), 86'd1);
        check("exc_valid", 86'(ms_to_ws_valid), 86'd1);
        check("exc_field", 86'(ms_to_ws_bus[15:0]), 86'h0200);
        check("exc_pc", 86'(ms_to_ws_bus[85:54]), 86'h1c00_0050);
        tick();
        check("exc_cleared", 86'(ms_except), 86'd0);

        // back-to-back ALU ops
        h0 = handoffs;
        for (int i = 0; i < 3; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus = mk(32'h1c00_0060 + 32'(4 * i), 32'h100 + 32'(i), 1'b1,
                              5'(10 + i), 1'b0, 1'b0, 5'b00000, 16'h0);
            tick();
            check("alu_rfc", 86'(ms_rf_collect), 86'({1'b0, 1'b1, 5'(10 + i), 32'h100 + 32'(i)}));
            check("alu_valid", 86'(ms_to_ws_valid), 86'd1);
            check("alu_allowin", 86'(ms_allowin), 86'd1);
        end
        es_to_ms_valid = 1'b0;
        tick();
        check("alu_throughput", 86'(handoffs - h0), 86'd3);

        // load extension corner cases
        for (int i = 0; i < 4; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus = mk(32'h1c00_0080, t_addr[i], 1'b1, 5'd3, 1'b1, 1'b1, t_lt[i], 16'h0);
            tick();
            es_to_ms_valid = 1'b0;
            data_sram_data_ok = 1'b1; data_sram_rdata = t_rd[i]; #1;
            check("ld_ext", 86'(fin(ms_to_ws_bus)), 86'(t_exp[i]));
            tick();
            data_sram_data_ok = 1'b0;
        end

        // reset mid-operation clears an orphan count
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h1c00_0090, 32'h7000, 1'b0, 5'd0, 1'b0, 1'b1, 5'b00000, 16'h0);
        tick();
        es_to_ms_valid = 1'b0; except_flush = 1'b1;
        tick();
        except_flush = 1'b0; #1;
        check("pre_rst_discard", 86'(dut.discard_cnt), 86'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1; #1;
        check("rst_discard", 86'(dut.discard_cnt), 86'd0);
        check("rst_mid_allowin", 86'(ms_allowin), 86'd1);

        tick();
        check("no_wrap", 86'(wrap_seen), 86'd0);
        check("no_double_ok", 86'(illegal_seen), 86'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
